ghr_checkpoint_ctrl: RTL



---
 rtl/ghr_checkpoint_ctrl_if.sv | 20 ++
 rtl/ghr_checkpoint_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ghr_checkpoint_ctrl_if.sv
// Prediction/resolution handshake between fetch, execute and the GHR
// checkpoint controller. The controller uses the slave modport.
interface ghr_checkpoint_ctrl_if;
    logic pred_valid;
    logic pred_taken;
    logic pred_ready;
    logic resolve_valid;
    logic resolve_taken;
    logic resolve_mispredict;

    modport master (
        output pred_valid, pred_taken, resolve_valid, resolve_taken, resolve_mispredict,
        input  pred_ready
    );

    modport slave (
        input  pred_valid, pred_taken, resolve_valid, resolve_taken, resolve_mispredict,
        output pred_ready
    );
endinterface

// File: rtl/ghr_checkpoint_ctrl.sv
// Speculative/committed global-history controller with an in-order checkpoint FIFO.
// Optional build macro GHR_CKPT_STATS_EN enables the saturating mispredict counter.
module ghr_checkpoint_ctrl #(
    parameter int GHR_W = 5,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    ghr_checkpoint_ctrl_if.slave br,
    input  logic                 flush,
    output logic [GHR_W-1:0]     ghr_spec,
    output logic [GHR_W-1:0]     ghr_arch,
    output logic [PTR_W:0]       count,
    output logic                 full,
    output logic                 empty,
    output logic                 recovering,
    output logic [15:0]          mispredict_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [GHR_W-1:0]   ghr_spec_r;
    logic [GHR_W-1:0]   ghr_arch_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W:0]     count_r;
    // The top bit of a pre-shift history is shifted out on restore, so it is not kept.
    logic [GHR_W-2:0]   ckpt_r [DEPTH];

    logic               full_s;
    logic               empty_s;
    logic               pred_ready_s;
    logic               recovering_s;
    logic               mispredict_s;
    logic               push_s;
    logic               pop_s;

    assign full_s  = (count_r == (PTR_W+1)'(DEPTH));
    assign empty_s = (count_r == {(PTR_W+1){1'b0}});

    // Next-state decode plus the state-derived outputs.
    always_comb begin
        state_s      = state_r;
        pred_ready_s = 1'b0;
        recovering_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                pred_ready_s = !full_s;
                if (flush) begin
                    state_s = ST_RUN;
                end else if (mispredict_s) begin
                    state_s = ST_RECOVER;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RECOVER: begin
                recovering_s = 1'b1;
                state_s      = ST_RUN;
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // Qualified FIFO/history events; flush outranks mispredict, which outranks push/pop.
    always_comb begin
        mispredict_s = br.resolve_valid && br.resolve_mispredict && !empty_s;
        if (flush || mispredict_s) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = br.pred_valid && pred_ready_s;
            pop_s  = br.resolve_valid && !br.resolve_mispredict && !empty_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Histories, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            ghr_spec_r <= {GHR_W{1'b0}};
            ghr_arch_r <= {GHR_W{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            ghr_spec_r <= ghr_arch_r;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
        end else if (mispredict_s) begin
            ghr_spec_r <= {ckpt_r[head_r], br.resolve_taken};
            ghr_arch_r <= {ghr_arch_r[GHR_W-2:0], br.resolve_taken};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                ghr_spec_r <= {ghr_spec_r[GHR_W-2:0], br.pred_taken};
                tail_r     <= tail_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                ghr_arch_r <= {ghr_arch_r[GHR_W-2:0], br.resolve_taken};
                head_r     <= head_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Checkpoint storage: pre-shift speculative history of each accepted branch.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ckpt_r[i] <= {(GHR_W-1){1'b0}};
            end
        end else if (push_s) begin
            ckpt_r[tail_r] <= ghr_spec_r[GHR_W-2:0];
        end
    end

`ifdef GHR_CKPT_STATS_EN
    logic [15:0] mispredict_cnt_r;
    logic        mp_accept_s;

    assign mp_accept_s = mispredict_s && !flush;

    // Saturating mispredict statistic, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict_cnt_r <= 16'h0000;
        end else if (mp_accept_s && (mispredict_cnt_r != 16'hFFFF)) begin
            mispredict_cnt_r <= mispredict_cnt_r + 16'h0001;
        end
    end

    assign mispredict_cnt = mispredict_cnt_r;
`else
    assign mispredict_cnt = 16'h0000;
`endif

    assign br.pred_ready = pred_ready_s;
    assign recovering    = recovering_s;
    assign ghr_spec      = ghr_spec_r;
    assign ghr_arch      = ghr_arch_r;
    assign count         = count_r;
    assign full          = full_s;
    assign empty         = empty_s;

endmodule
